// File: rtl/glip_downscale_buf.sv
// Width downscaler for GLIP valid/ready FIFO interfaces.
// Splits each IN_SIZE-bit word into IN_SIZE/OUT_SIZE chunks, MSB chunk first.
module glip_downscale_buf #(
    parameter int IN_SIZE  = 16,
    parameter int OUT_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_SIZE-1:0]  in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUT_SIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    localparam int RATIO = IN_SIZE / OUT_SIZE;

    generate
        if (IN_SIZE != OUT_SIZE && IN_SIZE != 2 * OUT_SIZE && IN_SIZE != 4 * OUT_SIZE) begin : g_bad_size
            $fatal(1, "glip_downscale_buf: IN_SIZE must be 1x, 2x or 4x OUT_SIZE");
        end

        if (RATIO == 1) begin : g_pass
            always_comb begin
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
                out_last  = 1'b1;
            end
        end else begin : g_buf
            localparam int CNT_W = $clog2(RATIO);
            localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

            typedef enum logic {
                EMPTY,
                EMIT
            } state_t;

            state_t             state_q, state_d;
            logic [CNT_W-1:0]   cnt_q, cnt_d;
            logic [IN_SIZE-1:0] buf_q, buf_d;
            logic               at_last;
            logic               in_hs;
            logic               out_hs;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= EMPTY;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // Word buffer carries no reset: its contents are ignored while EMPTY.
            always_ff @(posedge clk) begin
                buf_q <= buf_d;
            end

            always_comb begin
                out_data = '0;
                for (int unsigned k = 0; k < RATIO; k++) begin
                    if (cnt_q == CNT_W'(RATIO - 1 - k)) begin
                        out_data = buf_q[k*OUT_SIZE +: OUT_SIZE];
                    end
                end
            end

            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                buf_d     = buf_q;
                at_last   = (cnt_q == LAST_CNT);
                out_valid = (state_q == EMIT);
                out_last  = (state_q == EMIT) && at_last;
                // A new word may only enter while the final chunk leaves.
                in_ready  = !rst && ((state_q == EMPTY) || (out_ready && at_last));
                in_hs     = in_valid && in_ready;
                out_hs    = out_valid && out_ready;

                case (state_q)
                    EMPTY: begin
                        if (in_hs) begin
                            buf_d   = in_data;
                            cnt_d   = '0;
                            state_d = EMIT;
                        end
                    end
                    EMIT: begin
                        if (out_hs) begin
                            if (!at_last) begin
                                cnt_d = cnt_q + 1'b1;
                            end else if (in_hs) begin
                                buf_d = in_data;
                                cnt_d = '0;
                            end else begin
                                cnt_d   = '0;
                                state_d = EMPTY;
                            end
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    endgenerate

endmodule

// File: tb/tb_glip_downscale_buf.sv
// Bench for glip_downscale_buf: 1:1, 2:1 and 4:1 instances checked against a chunk-queue model.
module tb_glip_downscale_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst2, iv2, ir2, ov2, or2, ol2;
    logic [15:0] id2;
    logic [7:0]  od2;

    logic        rst4, iv4, ir4, ov4, or4, ol4;
    logic [31:0] id4;
    logic [7:0]  od4;

    logic        rst1, iv1, ir1, ov1, or1, ol1;
    logic [7:0]  id1;
    logic [7:0]  od1;

    glip_downscale_buf #(.IN_SIZE(16), .OUT_SIZE(8)) u_dut2 (
        .clk(clk), .rst(rst2), .in_data(id2), .in_valid(iv2), .in_ready(ir2),
        .out_data(od2), .out_valid(ov2), .out_ready(or2), .out_last(ol2)
    );

    glip_downscale_buf #(.IN_SIZE(32), .OUT_SIZE(8)) u_dut4 (
        .clk(clk), .rst(rst4), .in_data(id4), .in_valid(iv4), .in_ready(ir4),
        .out_data(od4), .out_valid(ov4), .out_ready(or4), .out_last(ol4)
    );

    glip_downscale_buf #(.IN_SIZE(8), .OUT_SIZE(8)) u_dut1 (
        .clk(clk), .rst(rst1), .in_data(id1), .in_valid(iv1), .in_ready(ir1),
        .out_data(od1), .out_valid(ov1), .out_ready(or1), .out_last(ol1)
    );

    // Model: pending chunks of the word in flight as {last, data}, MSB chunk first.
    logic [8:0]  q2[$];
    logic [8:0]  q4[$];
    logic [7:0]  log2[$];
    logic [7:0]  log4[$];
    logic [15:0] sent2[$];
    logic [15:0] asm2 = '0;
    int          words_in2  = 0;
    int          words_out2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step2(input logic r, input logic v, input logic [15:0] d, input logic rd);
        logic exp_ir;
        rst2 = r; iv2 = v; id2 = d; or2 = rd;
        iv4 = 1'b0; or4 = 1'b0;
        @(negedge clk);
        exp_ir = !r && (q2.size() == 0 || (q2.size() == 1 && rd));
        chk("in_ready2", 32'(ir2), 32'(exp_ir));
        chk("out_valid2", 32'(ov2), 32'(q2.size() != 0));
        if (q2.size() != 0) begin
            chk("out_data2", 32'(od2), 32'(q2[0][7:0]));
            chk("out_last2", 32'(ol2), 32'(q2[0][8]));
            if (rd) begin
                log2.push_back(od2);
                asm2 = {asm2[7:0], od2};
                if (q2[0][8] && !r) begin
                    chk("rt_pending", 32'(sent2.size() != 0), 32'd1);
                    if (sent2.size() != 0) begin
                        chk("roundtrip2", 32'(asm2), 32'(sent2.pop_front()));
                        words_out2++;
                    end
                end
                void'(q2.pop_front());
            end
        end
        if (r) begin
            q2.delete();
            sent2.delete();
        end else if (v && exp_ir) begin
            q2.push_back({1'b0, d[15:8]});
            q2.push_back({1'b1, d[7:0]});
            sent2.push_back(d);
            words_in2++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic r, input logic v, input logic [31:0] d, input logic rd);
        logic exp_ir;
        rst4 = r; iv4 = v; id4 = d; or4 = rd;
        iv2 = 1'b0; or2 = 1'b0;
        @(negedge clk);
        exp_ir = !r && (q4.size() == 0 || (q4.size() == 1 && rd));
        chk("in_ready4", 32'(ir4), 32'(exp_ir));
        chk("out_valid4", 32'(ov4), 32'(q4.size() != 0));
        if (q4.size() != 0) begin
            chk("out_data4", 32'(od4), 32'(q4[0][7:0]));
            chk("out_last4", 32'(ol4), 32'(q4[0][8]));
            if (rd) begin
                log4.push_back(od4);
                void'(q4.pop_front());
            end
        end
        if (r) begin
            q4.delete();
        end else if (v && exp_ir) begin
            for (int k = 3; k >= 0; k--) begin
                q4.push_back({k == 0, d[k*8 +: 8]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_bb[6];
        logic [7:0] exp_bp[8];
        logic [7:0] exp_rm[5];
        bit         done;

        rst2 = 1'b1; iv2 = 1'b0; id2 = '0; or2 = 1'b0;
        rst4 = 1'b1; iv4 = 1'b0; id4 = '0; or4 = 1'b0;
        rst1 = 1'b1; iv1 = 1'b0; id1 = '0; or1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with in_valid high, then released.
        repeat (3) step2(1'b1, 1'b1, 16'hFFFF, 1'b1);
        step2(1'b0, 1'b0, 16'h0000, 1'b0);

        // 2:1 single word.
        log2.delete();
        step2(1'b0, 1'b1, 16'hA55A, 1'b1);
        repeat (3) step2(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("a55a_count", 32'(log2.size()), 32'd2);
        if (log2.size() == 2) begin
            chk("a55a_msb", 32'(log2[0]), 32'h A5);
            chk("a55a_lsb", 32'(log2[1]), 32'h5A);
        end

        // 2:1 back-to-back: second and third words are taken on the last-chunk cycles.
        log2.delete();
        exp_bb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        step2(1'b0, 1'b1, 16'h1234, 1'b1);
        step2(1'b0, 1'b1, 16'h5678, 1'b1);
        step2(1'b0, 1'b1, 16'h5678, 1'b1);
        step2(1'b0, 1'b1, 16'h9ABC, 1'b1);
        step2(1'b0, 1'b1, 16'h9ABC, 1'b1);
        repeat (3) step2(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("b2b_count", 32'(log2.size()), 32'd6);
        for (int i = 0; i < 6 && i < log2.size(); i++) begin
            chk("b2b_chunk", 32'(log2[i]), 32'(exp_bb[i]));
        end

        // 4:1 with backpressure; a second word waits on in_valid until the EF handshake.
        step4(1'b1, 1'b0, 32'h0, 1'b0);
        log4.delete();
        exp_bp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        step4(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        step4(1'b0, 1'b1, 32'h01020304, 1'b1);
        step4(1'b0, 1'b1, 32'h01020304, 1'b0);
        step4(1'b0, 1'b1, 32'h01020304, 1'b0);
        step4(1'b0, 1'b1, 32'h01020304, 1'b1);
        step4(1'b0, 1'b1, 32'h01020304, 1'b1);
        step4(1'b0, 1'b1, 32'h01020304, 1'b0);
        step4(1'b0, 1'b1, 32'h01020304, 1'b1);
        repeat (5) step4(1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp_count", 32'(log4.size()), 32'd8);
        for (int i = 0; i < 8 && i < log4.size(); i++) begin
            chk("bp_chunk", 32'(log4[i]), 32'(exp_bp[i]));
        end

        // 4:1 reset mid-word discards the remaining chunks.
        log4.delete();
        exp_rm = '{8'h11, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        step4(1'b0, 1'b1, 32'h11223344, 1'b1);
        step4(1'b0, 1'b0, 32'h0, 1'b1);
        step4(1'b1, 1'b0, 32'h0, 1'b0);
        step4(1'b0, 1'b0, 32'h0, 1'b1);
        step4(1'b0, 1'b1, 32'hAABBCCDD, 1'b1);
        repeat (5) step4(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_count", 32'(log4.size()), 32'd5);
        for (int i = 0; i < 5 && i < log4.size(); i++) begin
            chk("rst_chunk", 32'(log4[i]), 32'(exp_rm[i]));
        end

        // 1:1 pass-through.
        rst1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            id1 = 8'($urandom);
            iv1 = 1'($urandom);
            or1 = 1'($urandom);
            @(negedge clk);
            chk("p1_data", 32'(od1), 32'(id1));
            chk("p1_valid", 32'(ov1), 32'(iv1));
            chk("p1_ready", 32'(ir1), 32'(or1));
            chk("p1_last", 32'(ol1), 32'd1);
            @(posedge clk);
            #1;
        end

        // 2:1 random traffic with stalls, reassembled and compared word by word.
        words_in2  = 0;
        words_out2 = 0;
        done       = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            step2(1'b0, (($urandom % 4) != 0) && (words_in2 < 1000), 16'($urandom),
                  ($urandom % 3) != 0);
            done = (words_in2 == 1000) && (q2.size() == 0);
        end
        chk("rand_drained", 32'(done), 32'd1);
        chk("rand_words_out", 32'(words_out2), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glip_downscale_buf.md
# glip_downscale_buf

Registered width downscaler for GLIP FIFO (valid/ready) interfaces: accepts an IN_SIZE-bit word and emits it as RATIO consecutive OUT_SIZE-bit chunks, most-significant chunk first. It is the transmit-side counterpart of the 2:1 upscaler, so a downscale→upscale chain restores the original word bit-exactly. It sits between wide logic-side FIFOs and the narrow communication-channel FIFOs. Ratios 1:1, 2:1 and 4:1 are supported.

## Interface
- IN_SIZE, 16, input word width in bits
- OUT_SIZE, 8, output chunk width in bits; IN_SIZE must equal OUT_SIZE, 2×OUT_SIZE or 4×OUT_SIZE, else elaboration-time `$fatal`
- RATIO (localparam), IN_SIZE/OUT_SIZE
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  IN_SIZE  input word
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  OUT_SIZE  current output chunk
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data this cycle
- out_last  out  1  current chunk is the final (least-significant) chunk of its word

## Operation
- RATIO=1: pure combinational pass-through: out_data=in_data, out_valid=in_valid, in_ready=out_ready, out_last=1. No state.
- RATIO=2/4: state is word buffer buf[IN_SIZE-1:0], occupancy flag full, chunk counter cnt (log2(RATIO) bits).
- Two states: EMPTY (full=0), EMIT (full=1).
- out_valid = full; out_last = full & (cnt==RATIO-1).
- out_data = buf chunk at index RATIO-1-cnt (chunk k = buf[k·OUT_SIZE +: OUT_SIZE]); cnt=0 gives MSB chunk.
- in_ready = !rst & (!full | (out_ready & cnt==RATIO-1)).
- Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
- EMPTY, input handshake: buf<=in_data, cnt<=0, full<=1 → EMIT.
- EMIT, output handshake with cnt<RATIO-1: cnt<=cnt+1; buf held.
- EMIT, output handshake with cnt==RATIO-1 and input handshake same cycle: buf<=in_data, cnt<=0, full stays 1 (no bubble).
- EMIT, last-chunk handshake without new input: cnt<=0, full<=0 → EMPTY.
- EMIT, out_ready=0: all state held; out_data, out_last stable (valid must not drop).
- Input never accepted mid-word (cnt<RATIO-1).
- Reset: full<=0, cnt<=0; buf not reset (don't care). Reset mid-word discards remaining chunks; no partial chunk emitted afterwards.

## Timing
- Outputs during/after reset: out_valid=0, out_last=0 from the first cycle after rst sampled high; in_ready=0 while rst=1, =1 in first cycle after rst deasserts.
- Latency: word accepted at edge N → its MSB chunk valid in the cycle after edge N (1 cycle).
- Throughput: with out_ready held 1 and in_valid held 1, one chunk per cycle continuously; one word accepted every RATIO cycles.
- in_ready depends combinationally on out_ready (only at last chunk); no combinational path in_valid→out_*, in_data→out_data.
- out_data/out_valid/out_last are functions of registers only (RATIO>1).

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → in_ready=0, out_valid=0 throughout; after release in_ready=1, out_valid=0.
- 2:1 single word: in_data=0xA55A, one handshake, out_ready=1 → next cycles out_data 0xA5 (out_last=0), then 0x5A (out_last=1), then out_valid=0.
- 2:1 back-to-back: words 0x1234, 0x5678, 0x9ABC with in_valid=1, out_ready=1 → output stream 0x12,0x34,0x56,0x78,0x9A,0xBC on 6 consecutive cycles, in_ready high on cycles emitting 0x34 and 0x78.
- 4:1 with backpressure (IN_SIZE=32, OUT_SIZE=8): word 0xDEADBEEF, out_ready toggled 1,0,0,1,1,0,1 → chunks DE,AD,BE,EF in order, each stable while stalled, in_ready=0 until EF handshake.
- Reset mid-word: 4:1, accept 0x11223344, consume 0x11, assert rst one cycle → out_valid=0 next cycle; subsequent word 0xAABBCCDD emits AA,BB,CC,DD only.
- 1:1 pass-through and round trip: RATIO=1 checks out_data=in_data and in_ready=out_ready each cycle; 2:1 downscaler feeding 2:1 upscaler with 1000 random words and random stalls → identical word sequence out.
